sample_sequencer: RTL

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

---
 rtl/sample_sequencer_pkg.sv | 28 ++
 rtl/sample_sequencer_mix.sv | 53 +++++
 rtl/sample_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_sequencer_pkg
// Purpose  : Shared encodings and defaults for the two-channel ADC-to-DAC
//            sample sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sample_sequencer_pkg;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd2000;
  localparam int          DW_DEFAULT      = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_START1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_OUTPUT = 3'd5
  } seq_state_e;

  localparam logic [1:0] SEL_CH0  = 2'b00;
  localparam logic [1:0] SEL_CH1  = 2'b01;
  localparam logic [1:0] SEL_AVG  = 2'b10;
  localparam logic [1:0] SEL_DIFF = 2'b11;

endpackage
`default_nettype wire

// File: rtl/sample_sequencer_mix.sv
`default_nettype none
// ============================================================================
// Module   : seq_mix
// Purpose  : Combinational DAC source select: ch0, ch1, truncated average, or
//            saturated offset-binary difference.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mix
  import sample_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] ch0_i,
  input  logic [DW-1:0] ch1_i,
  input  logic [1:0]    sel_i,
  output logic [DW-1:0] mix_o
);

  localparam logic [DW+1:0] C_HALF = {2'b00, 1'b1, {(DW-1){1'b0}}};

  logic [DW:0]   w_sum;
  logic [DW-1:0] w_avg;
  logic [DW+1:0] w_diff;
  logic [DW-1:0] w_sat;

  assign w_sum = {1'b0, ch0_i} + {1'b0, ch1_i};
  assign w_avg = DW'(w_sum >> 1);

  // Two guard bits: bit DW+1 flags a negative result, bit DW an overflow.
  assign w_diff = {2'b00, ch0_i} - {2'b00, ch1_i} + C_HALF;

  always_comb begin
    w_sat = w_diff[DW-1:0];
    if (w_diff[DW+1]) begin
      w_sat = '0;
    end else if (w_diff[DW]) begin
      w_sat = '1;
    end
  end

  always_comb begin
    mix_o = ch0_i;
    case (sel_i)
      SEL_CH0:  mix_o = ch0_i;
      SEL_CH1:  mix_o = ch1_i;
      SEL_AVG:  mix_o = w_avg;
      SEL_DIFF: mix_o = w_sat;
      default:  mix_o = ch0_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sample_sequencer
// Purpose  : Per-tick two-channel ADC conversion sequence with timeout,
//            overrun detection and a mixed DAC output.
// Revision : 1.0 - initial release
// ============================================================================
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT,
  parameter int          DW      = DW_DEFAULT
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [1:0]    dac_sel,
  input  logic          clr_err,
  output logic          adc_start,
  output logic          adc_channel,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_data_valid,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic [DW-1:0] ch0_sample,
  output logic [DW-1:0] ch1_sample,
  output logic          frame_done,
  output logic          overrun_err,
  output logic          timeout_err
);

  seq_state_e    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] ch0_q, ch0_d;
  logic [DW-1:0] ch1_q, ch1_d;
  logic [DW-1:0] dac_q, dac_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;

  logic [16:0]   w_cnt_inc;
  logic          w_tmo_hit;
  logic          w_set_tmo;
  logic [DW-1:0] w_mix;

  seq_mix #(
    .DW (DW)
  ) u_mix (
    .ch0_i (ch0_q),
    .ch1_i (ch1_q),
    .sel_i (dac_sel),
    .mix_o (w_mix)
  );

  // The current wait cycle is the TIMEOUT-th one when count+1 reaches TIMEOUT.
  assign w_cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign w_tmo_hit = (w_cnt_inc >= {1'b0, TIMEOUT});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch0_d       = ch0_q;
    ch1_d       = ch1_q;
    dac_d       = dac_q;
    w_set_tmo   = 1'b0;
    adc_start   = 1'b0;
    adc_channel = 1'b0;
    dac_load    = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_START0;
      end
      ST_START0: begin
        adc_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT0;
      end
      ST_WAIT0: begin
        cnt_d = w_cnt_inc[15:0];
        if (adc_data_valid) begin
          ch0_d   = adc_data;
          state_d = ST_START1;
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          state_d   = ST_START1;
        end
      end
      ST_START1: begin
        adc_start   = 1'b1;
        adc_channel = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT1;
      end
      ST_WAIT1: begin
        adc_channel = 1'b1;
        cnt_d       = w_cnt_inc[15:0];
        if (adc_data_valid) begin
          ch1_d   = adc_data;
          state_d = ST_OUTPUT;
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          state_d   = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        dac_load   = 1'b1;
        frame_done = 1'b1;
        dac_d      = w_mix;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear first so a coincident set condition takes precedence.
    tmo_d = clr_err ? 1'b0 : tmo_q;
    ovr_d = clr_err ? 1'b0 : ovr_q;
    if (w_set_tmo)                     tmo_d = 1'b1;
    if (tick && (state_q != ST_IDLE))  ovr_d = 1'b1;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch0_q   <= '0;
      ch1_q   <= '0;
      dac_q   <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      dac_q   <= dac_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  // dac_sel is only looked at in OUTPUT, so the new value is presented
  // straight from the mixer in the load cycle and held in dac_q afterwards.
  assign dac_data    = (state_q == ST_OUTPUT) ? w_mix : dac_q;
  assign ch0_sample  = ch0_q;
  assign ch1_sample  = ch1_q;
  assign overrun_err = ovr_q;
  assign timeout_err = tmo_q;

endmodule
`default_nettype wire
